// File: rtl/alu_mul_sequencer_if.sv
// Multiplier-sequencer bus: CPU operand/start handshake plus the borrowed ALU port.
// Latency: n/a (signal bundle only).
// Backpressure: none; the CPU stalls on Busy and routes ALU inputs from the slave while AluGrant is high.
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 24
);
    // CPU request side
    logic               Start;
    logic [WIDTH-1:0]   Multiplicand;
    logic [WIDTH-1:0]   Multiplier;

    // ALU control driven by the sequencer
    logic [WIDTH-1:0]   AluA;
    logic [WIDTH-1:0]   AluB;
    logic               AluAInvert;
    logic               AluBNegate;
    logic [1:0]         AluOp;

    // ALU results returned by the datapath
    logic [WIDTH-1:0]   AluResult;
    logic               AluCarryOut;
    logic               AluOverflow;

    // Status and result
    logic               AluGrant;
    logic               Busy;
    logic               Done;
    logic [2*WIDTH-1:0] Product;

    // CPU / datapath side
    modport master (
        output Start, Multiplicand, Multiplier,
        output AluResult, AluCarryOut, AluOverflow,
        input  AluA, AluB, AluAInvert, AluBNegate, AluOp,
        input  AluGrant, Busy, Done, Product
    );

    // Sequencer side
    modport slave (
        input  Start, Multiplicand, Multiplier,
        input  AluResult, AluCarryOut, AluOverflow,
        output AluA, AluB, AluAInvert, AluBNegate, AluOp,
        output AluGrant, Busy, Done, Product
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier controller time-sharing the CPU ALU; optional signed mode via ALU_MUL_SIGNED_EN.
// Latency: Start accepted at edge 0, 24 RUN cycles, Done pulses in the cycle after edge 24 (25 cycles).
// Backpressure: Start is honoured only in IDLE; requests in RUN/DONE are dropped, the CPU stalls on Busy.
module alu_mul_sequencer #(
    parameter int WIDTH = 24
) (
    input  logic               Clock,
    input  logic               ResetN,
    alu_mul_sequencer_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    count;
    logic             busy;
    logic             grant;
    logic             done;
    logic [1:0]       alu_op;

    logic             last_step;
    logic             shift_in;
    logic             b_negate;

    assign last_step = (count == LAST_COUNT);

`ifdef ALU_MUL_SIGNED_EN
    // Signed: the true sign of the 25-bit sum is the result MSB corrected by overflow,
    // and the multiplier's sign bit carries negative weight, so the final step subtracts.
    assign shift_in = bus.AluResult[WIDTH-1] ^ bus.AluOverflow;
    assign b_negate = (state == S_RUN) && last_step && lo[0];

    logic unused_carry;
    assign unused_carry = bus.AluCarryOut;
`else
    // Unsigned: the carry out is the 25th bit of the partial sum.
    assign shift_in = bus.AluCarryOut;
    assign b_negate = 1'b0;

    logic unused_ovf;
    assign unused_ovf = bus.AluOverflow;
`endif

    // ALU operands come straight from the accumulator and captured multiplicand.
    assign bus.AluA       = hi;
    assign bus.AluB       = lo[0] ? m_reg : '0;
    assign bus.AluAInvert = 1'b0;
    assign bus.AluBNegate = b_negate;
    assign bus.AluOp      = alu_op;
    assign bus.AluGrant   = grant;
    assign bus.Busy       = busy;
    assign bus.Done       = done;
    assign bus.Product    = {hi, lo};

    // Controller FSM with registered status outputs and the accumulator shift.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state  <= S_IDLE;
            m_reg  <= '0;
            hi     <= '0;
            lo     <= '0;
            count  <= '0;
            busy   <= 1'b0;
            grant  <= 1'b0;
            done   <= 1'b0;
            alu_op <= OP_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.Start) begin
                        m_reg  <= bus.Multiplicand;
                        lo     <= bus.Multiplier;
                        hi     <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        grant  <= 1'b1;
                        alu_op <= OP_ADD;
                        state  <= S_RUN;
                    end
                end

                S_RUN: begin
                    // {Hi, Lo} <= {ShiftIn, AluResult, Lo} >> 1
                    hi    <= {shift_in, bus.AluResult[WIDTH-1:1]};
                    lo    <= {bus.AluResult[0], lo[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (last_step) begin
                        busy   <= 1'b0;
                        grant  <= 1'b0;
                        alu_op <= OP_NONE;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end

                S_DONE: begin
                    // Product stays in {hi, lo} until the next accepted Start.
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy   <= 1'b0;
                    grant  <= 1'b0;
                    done   <= 1'b0;
                    alu_op <= OP_NONE;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle shift-and-add multiplier controller that time-shares the CPU's 24-bit ALU to produce a 48-bit product. While busy it owns the ALU operand and control inputs, requesting one add per cycle and shifting the accumulator from the ALU result and carry. It sits beside the single-cycle datapath. The CPU stalls on `Busy` and muxes ALU inputs from this block while `AluGrant` is high.

## Interface
- `WIDTH`, 24: operand width. Must match the ALU width.
- `Clock`  in  1  rising-edge clock.
- `ResetN`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request a multiply; sampled only in IDLE.
- `Multiplicand`  in  24  operand M; captured on accepted Start.
- `Multiplier`  in  24  operand Q; captured on accepted Start.
- `AluA`  out  24  ALU A input; equals accumulator high half Hi.
- `AluB`  out  24  ALU B input; Mreg when Lo[0]=1, else 0.
- `AluAInvert`  out  1  always 0.
- `AluBNegate`  out  1  always 0, except in signed mode (see Configuration).
- `AluOp`  out  2  2'b10 (ADD) while RUN, 2'b00 otherwise.
- `AluResult`  in  24  ALU Result.
- `AluCarryOut`  in  1  ALU CarryOut.
- `AluOverflow`  in  1  ALU Overflow; used only in signed mode.
- `AluGrant`  out  1  high while in RUN; the datapath routes ALU inputs from this block.
- `Busy`  out  1  high in RUN.
- `Done`  out  1  one-cycle pulse in DONE.
- `Product`  out  48  {Hi, Lo}; valid from DONE until the next accepted Start.

## Operation
- Registers: Mreg[23:0], Hi[23:0], Lo[23:0], Count[4:0], state.
- States: IDLE, RUN, DONE.
- IDLE:
  - On Start=1: Mreg←Multiplicand, Lo←Multiplier, Hi←0, Count←0, go to RUN.
  - On Start=0: all registers hold.
- RUN, each cycle:
  - The ALU computes Hi + (Lo[0] ? Mreg : 0).
  - ShiftIn = AluCarryOut (unsigned mode).
  - {Hi, Lo} ← {ShiftIn, AluResult, Lo} >> 1. That is: Hi ← {ShiftIn, AluResult[23:1]}, Lo ← {AluResult[0], Lo[23:1]}.
  - Count←Count+1. When Count==23 this cycle, go to DONE.
- DONE: Done=1 for one cycle, then return to IDLE. Product holds.
- Start while in RUN or DONE is ignored; no queueing.
- Arithmetic is modulo 2^48. The product is exact for all unsigned 24-bit operands.
- ALU outputs are consumed combinationally in the same cycle they are requested. No wait states.

## Timing
- Reset (ResetN=0, asynchronous): state=IDLE, Hi=Lo=Mreg=0, Count=0. As a result Busy=0, Done=0, AluGrant=0, AluOp=2'b00, AluA=AluB=0, AluBNegate=0, Product=0.
- Reset asserted mid-RUN aborts immediately. There is no Done and Product=0.
- Latency: Start sampled at edge 0 → RUN for edges 1..24 → DONE is visible in the cycle after edge 24 → IDLE after edge 25.
- From accepted Start to the Done pulse is 25 cycles. The earliest next accepted Start is 26 cycles after the first.
- Busy and AluGrant rise in the first cycle after Start is accepted and fall as DONE begins. They are exactly 24 cycles wide.
- Product is stable and readable from the DONE cycle until the edge that accepts the next Start.

## Configuration
- `ALU_MUL_SIGNED_EN` defined: two's-complement signed multiply.
  - ShiftIn = AluResult[23] XOR AluOverflow, which gives the true sign of the sum.
  - In the last RUN cycle (Count==23) with Lo[0]=1, AluBNegate=1, so the ALU computes Hi − Mreg.
  - Product is the signed 48-bit result.
- `ALU_MUL_SIGNED_EN` undefined: unsigned only. AluBNegate is tied to 0, AluOverflow is ignored and ShiftIn = AluCarryOut.
- Ports are identical in both builds.

## Test plan
- Unsigned small values: Multiplicand=3, Multiplier=5 → Done exactly 25 cycles after Start; Product=48'h00000000000F.
- Unsigned maximum (unsigned build): 24'hFFFFFF × 24'hFFFFFF → Product=48'hFFFFFE000001. Busy is high for exactly 24 cycles.
- Signed build:
  - 24'hFFFFFF × 24'hFFFFFF (−1 × −1) → Product=48'h000000000001.
  - 24'h000007 × 24'hFFFFFE → Product=48'hFFFFFFFFFFF2.
- Start pulsed during RUN, with new operands 2 × 2 → ignored. Product equals the first operation's result, and only one Done pulse occurs.
- ResetN pulsed low at RUN cycle 10 → Busy, AluGrant and Done are 0 immediately and Product=0. A following Start 6 × 7 gives Product=42 after 25 cycles.
- Back-to-back: Start held high continuously → a new operation is accepted every 26 cycles. Each Done pulse is one cycle wide.
